// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FWFT FIFO with flags, flush and high-water mark
// Any DEPTH >= 2 is legal: pointers wrap on an explicit compare rather than binary overflow.
module param_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  peak
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be >= 2");
  end
  if (!(AE_THRESH >= 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("param_sync_fifo: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  peak_q, peak_d;
  logic              push, pop;

  // Handshakes depend only on registered state and flush, never on the opposite side.
  assign in_ready     = (count_q != DEPTH_C) & ~flush;
  assign out_valid    = (count_q != '0) & ~flush;
  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign out_data     = mem_q[rd_ptr_q];
  assign count        = count_q;
  assign peak         = peak_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
    peak_d = flush ? '0 : ((count_d > peak_q) ? count_d : peak_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
    end
  end

  // Storage is deliberately not reset; contents are only visible behind out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - scoreboard bench for param_sync_fifo (DEPTH=5, AF=3, AE=1)
module tb_param_sync_fifo;

  localparam int DEPTH = 5;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] peak;

  param_sync_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty), .peak(peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  int m_count = 0;
  int m_peak  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle: inputs set after negedge, model compared before the posedge, model advanced after.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    logic e_ready, e_valid, m_push, m_pop;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    e_ready = (m_count != DEPTH) && !fl;
    e_valid = (m_count != 0) && !fl;
    check("in_ready", in_ready, e_ready);
    check("out_valid", out_valid, e_valid);
    check("count", count, m_count);
    check("peak", peak, m_peak);
    check("almost_full", almost_full, m_count >= AF);
    check("almost_empty", almost_empty, m_count <= AE);
    if (e_valid && sb.size() > 0) check("out_data", out_data, sb[0]);
    m_push = iv && e_ready;
    m_pop  = ordy && e_valid;
    @(posedge clk);
    if (fl) begin
      m_count = 0;
      m_peak  = 0;
      sb.delete();
    end else begin
      if (m_pop)  void'(sb.pop_front());
      if (m_push) sb.push_back(d);
      m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      if (m_count > m_peak) m_peak = m_count;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_async_count", count, 0);
    check("rst_async_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: fill, head stays 0x11; extra push while full is refused
    step(0, 8'h00, 0, 0);
    for (int i = 1; i <= 5; i++) step(1, 8'(i * 17), 0, 0);
    step(1, 8'hEE, 0, 0);
    check("full_peak", peak, 5);
    check("full_head", out_data, 8'h11);

    // 2: drain in order
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    check("empty_count", count, 0);

    // 3: steady push+pop at count=2 across pointer wraps
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 8'($urandom_range(0, 255)), 1, 0);
    check("wrap_count", count, 2);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);

    // 4: full with push+pop -> pop only, then push accepted
    for (int i = 0; i < 5; i++) step(1, 8'(8'hB0 + i), 0, 0);
    step(1, 8'hC0, 1, 0);
    check("fullpop_count", count, 4);
    step(1, 8'hC1, 0, 0);
    check("refill_count", count, 5);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);

    // 5: no same-cycle pass-through when empty
    step(1, 8'hA5, 0, 0);
    check("fwft_valid", out_valid, 1);
    check("fwft_data", out_data, 8'hA5);
    step(0, 8'h00, 1, 0);

    // 6: flush at count=3 beats push/pop, then async reset mid-burst
    for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0, 0);
    step(1, 8'h77, 1, 1);
    step(0, 8'h00, 0, 0);
    check("flush_peak", peak, 0);
    for (int i = 0; i < 3; i++) step(1, 8'(8'h90 + i), 0, 0);
    in_valid = 1'b1; out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_peak", peak, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_ae", almost_empty, 1);
    check("midrst_af", almost_full, 0);
    m_count = 0; m_peak = 0; sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h3C, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
